// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, functs, ALU/mux selects, FSM states.
// MC_CTRL_IMM_LOGIC_EN adds the IMMEX state used by andi/ori.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND  = 3'd0;
  localparam logic [2:0] ALU_OR   = 3'd1;
  localparam logic [2:0] ALU_ADD  = 3'd2;
  localparam logic [2:0] ALU_ANDN = 3'd4;
  localparam logic [2:0] ALU_ORN  = 3'd5;
  localparam logic [2:0] ALU_SUB  = 3'd6;
  localparam logic [2:0] ALU_SLT  = 3'd7;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [2:0] {
    ALUOP_ADD   = 3'd0,
    ALUOP_SUB   = 3'd1,
    ALUOP_FUNCT = 3'd2,
    ALUOP_AND   = 3'd3,
    ALUOP_OR    = 3'd4
  } alu_op_t;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
`ifdef MC_CTRL_IMM_LOGIC_EN
    , S_IMMEX = 4'd12
`endif
  } state_t;

endpackage

// File: rtl/mc_controller_aludec.sv
// ALU decoder: maps the FSM's ALU operation request and the R-type funct field to ALUControl.
module aludec
  import mips_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       funct_ok
);

  always_comb begin
    funct_ok = 1'b0;
    case (funct)
      FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_SLT: funct_ok = 1'b1;
      default: funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_AND: alu_control = ALU_AND;
      ALUOP_OR:  alu_control = ALU_OR;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alu_control = ALU_ADD;
          FUNCT_SUB: alu_control = ALU_SUB;
          FUNCT_AND: alu_control = ALU_AND;
          FUNCT_OR:  alu_control = ALU_OR;
          FUNCT_SLT: alu_control = ALU_SLT;
          default:   alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM (Moore); define MC_CTRL_IMM_LOGIC_EN to make andi/ori legal via IMMEX.
//   state  | meaning
//   FETCH  | IR <= mem[PC], PC <= PC+4
//   DECODE | read regs, compute branch target, dispatch on Op (illegal -> FETCH)
//   MEMADR | address = A + SignImm
//   MEMRD  | read data memory
//   MEMWB  | write load data to rt
//   MEMWR  | write B to data memory
//   EXEC   | R-type ALU operation
//   ALUWB  | write ALU result to rd
//   BRANCH | compare A/B, PC <= target if equal
//   ADDIEX | A + SignImm
//   ADDIWB | write immediate result to rt
//   JUMP   | PC <= jump target
//   IMMEX  | A and/or immediate (MC_CTRL_IMM_LOGIC_EN only)
module mc_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic [2:0] ALUControl,
  output logic       IllegalOp
);

  state_t  state, state_next;
  alu_op_t alu_op;
  logic    pc_write, branch, funct_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

`ifdef MC_CTRL_IMM_LOGIC_EN
  // Latched in DECODE so IMMEX outputs stay a function of registered state only.
  logic imm_or;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  imm_or <= 1'b0;
    else if (state == S_DECODE) imm_or <= (Op == OP_ORI);
  end
`endif

  // Reset gates every output combinationally so nothing glitches while reset is held.
  always_comb begin
    state_next = S_FETCH;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    PCSrc      = PCSRC_ALU;
    alu_op     = ALUOP_ADD;
    pc_write   = 1'b0;
    branch     = 1'b0;
    IllegalOp  = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          IRWrite    = 1'b1;
          pc_write   = 1'b1;
          ALUSrcB    = SRCB_FOUR;
          state_next = S_DECODE;
        end
        S_DECODE: begin
          ALUSrcB = SRCB_IMMSH;
          case (Op)
            OP_LW, OP_SW: state_next = S_MEMADR;
            OP_RTYPE: begin
              if (funct_ok) state_next = S_EXEC;
              else          IllegalOp  = 1'b1;
            end
            OP_BEQ:  state_next = S_BRANCH;
            OP_ADDI: state_next = S_ADDIEX;
            OP_J:    state_next = S_JUMP;
`ifdef MC_CTRL_IMM_LOGIC_EN
            OP_ANDI, OP_ORI: state_next = S_IMMEX;
`endif
            default: IllegalOp = 1'b1;
          endcase
        end
        S_MEMADR: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = SRCB_IMM;
          state_next = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          IorD       = 1'b1;
          state_next = S_MEMWB;
        end
        S_MEMWB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        S_MEMWR: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        S_EXEC: begin
          ALUSrcA    = 1'b1;
          alu_op     = ALUOP_FUNCT;
          state_next = S_ALUWB;
        end
        S_ALUWB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA = 1'b1;
          alu_op  = ALUOP_SUB;
          PCSrc   = PCSRC_ALUOUT;
          branch  = 1'b1;
        end
        S_ADDIEX: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = SRCB_IMM;
          state_next = S_ADDIWB;
        end
        S_ADDIWB: RegWrite = 1'b1;
        S_JUMP: begin
          PCSrc    = PCSRC_JUMP;
          pc_write = 1'b1;
        end
`ifdef MC_CTRL_IMM_LOGIC_EN
        S_IMMEX: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = SRCB_IMM;
          alu_op     = imm_or ? ALUOP_OR : ALUOP_AND;
          state_next = S_ADDIWB;
        end
`endif
        default: state_next = S_FETCH;
      endcase
    end
  end

  aludec u_aludec (
    .alu_op      (alu_op),
    .funct       (Funct),
    .alu_control (ALUControl),
    .funct_ok    (funct_ok)
  );

  assign PCEn = pc_write | (branch & Zero);

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: instruction-level reference model, directed and random sequences.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] Op = 6'd0;
  logic [5:0] Funct = 6'd0;
  logic       Zero = 1'b0;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn, IllegalOp;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic [15:0] obs;

  int checks = 0;
  int errors = 0;

`ifdef MC_CTRL_IMM_LOGIC_EN
  localparam bit IMM_EN = 1'b1;
`else
  localparam bit IMM_EN = 1'b0;
`endif

  mc_controller dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSrc(PCSrc), .PCEn(PCEn), .ALUControl(ALUControl), .IllegalOp(IllegalOp)
  );

  always #5 clk = ~clk;

  assign obs = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                ALUSrcB, PCSrc, PCEn, ALUControl, IllegalOp};

  function automatic logic [15:0] pk(logic iord, logic memw, logic irw, logic regdst,
                                     logic m2r, logic regw, logic srca, logic [1:0] srcb,
                                     logic [1:0] pcsrc, logic pcen, logic [2:0] aluc, logic ill);
    return {iord, memw, irw, regdst, m2r, regw, srca, srcb, pcsrc, pcen, aluc, ill};
  endfunction

  function automatic logic [15:0] idle_vec();
    return pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'd2, 0);
  endfunction

  function automatic logic [2:0] funct_alu(logic [5:0] f);
    case (f)
      6'b100000: return 3'd2;
      6'b100010: return 3'd6;
      6'b100100: return 3'd0;
      6'b100101: return 3'd1;
      6'b101010: return 3'd7;
      default:   return 3'd2;
    endcase
  endfunction

  function automatic bit legal(logic [5:0] op, logic [5:0] f);
    case (op)
      6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010: return 1'b1;
      6'b000000: return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      6'b001100, 6'b001101: return IMM_EN;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int ilen(logic [5:0] op, logic [5:0] f);
    if (!legal(op, f)) return 2;
    case (op)
      6'b100011: return 5;
      6'b000100, 6'b000010: return 3;
      default: return 4;
    endcase
  endfunction

  // Expected outputs in cycle k of an instruction, from the per-instruction step lists.
  function automatic logic [15:0] exp_cycle(logic [5:0] op, logic [5:0] f, int k, logic z);
    if (k == 0) return pk(0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 1, 3'd2, 0);
    if (k == 1) return pk(0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 3'd2, !legal(op, f));
    case (op)
      6'b100011, 6'b101011: begin
        if (k == 2) return pk(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 3'd2, 0);
        if (k == 3 && op == 6'b100011) return pk(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'd2, 0);
        if (k == 3) return pk(1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'd2, 0);
        if (k == 4) return pk(0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 3'd2, 0);
      end
      6'b000000: begin
        if (k == 2) return pk(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, funct_alu(f), 0);
        if (k == 3) return pk(0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 3'd2, 0);
      end
      6'b000100: if (k == 2) return pk(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, z, 3'd6, 0);
      6'b001000, 6'b001100, 6'b001101: begin
        if (k == 2) return pk(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0,
                              (op == 6'b001100) ? 3'd0 : (op == 6'b001101) ? 3'd1 : 3'd2, 0);
        if (k == 3) return pk(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 3'd2, 0);
      end
      6'b000010: if (k == 2) return pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 1, 3'd2, 0);
      default: ;
    endcase
    return idle_vec();
  endfunction

  // Called at posedge+1: drives inputs, samples mid-cycle, advances to the next posedge+1.
  task automatic drive_cycle(input logic [5:0] op, input logic [5:0] f, input logic z,
                             output logic [15:0] o);
    Op = op; Funct = f; Zero = z;
    #2;
    o = obs;
    @(posedge clk);
    #1;
  endtask

  // zmode: 0 Zero low, 1 Zero high, 2 random each cycle.
  task automatic test_seq(input string name, input logic [5:0] op, input logic [5:0] f,
                          input int zmode);
    logic [15:0] o, e;
    logic z;
    for (int k = 0; k < ilen(op, f); k++) begin
      z = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      e = exp_cycle(op, f, k, z);
      drive_cycle(op, f, z, o);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s op=%b funct=%b cycle=%0d: got %b expected %b", name, op, f, k, o, e);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== idle_vec()) begin
      errors++;
      $display("FAIL reset_hold: got %b expected %b", obs, idle_vec());
    end
    reset = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [15:0] o, e;
    for (int k = 0; k < 3; k++) begin
      e = exp_cycle(6'b101011, 6'd0, k, 1'b0);
      drive_cycle(6'b101011, 6'd0, 1'b0, o);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL sw_pre_reset cycle=%0d: got %b expected %b", k, o, e);
      end
    end
    #2;
    checks++;
    if (MemWrite !== 1'b1) begin
      errors++;
      $display("FAIL memwr_before_reset: MemWrite got %b expected 1", MemWrite);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== idle_vec()) begin
      errors++;
      $display("FAIL reset_async: got %b expected %b", obs, idle_vec());
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs !== idle_vec()) begin
      errors++;
      $display("FAIL reset_across_edge: got %b expected %b", obs, idle_vec());
    end
    reset = 1'b0;
  endtask

  task automatic test_random(input int n);
    logic [5:0] ops[9];
    logic [5:0] functs[5];
    logic [5:0] op, f;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000,
            6'b000010, 6'b001100, 6'b001101, 6'b000000};
    functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(0, 8)];
      if ($urandom_range(0, 3) == 0) f = 6'($urandom);
      else f = functs[$urandom_range(0, 4)];
      test_seq("random", op, f, 2);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_seq("lw", 6'b100011, 6'b000000, 2);
    test_seq("rtype_slt", 6'b000000, 6'b101010, 2);
    test_seq("rtype_sub", 6'b000000, 6'b100010, 2);
    test_seq("beq_taken", 6'b000100, 6'b000000, 1);
    test_seq("beq_not_taken", 6'b000100, 6'b000000, 0);
    test_seq("sw", 6'b101011, 6'b000000, 2);
    test_seq("addi", 6'b001000, 6'b000000, 2);
    test_seq("jump", 6'b000010, 6'b000000, 0);
    test_seq("illegal_op", 6'b111111, 6'b000000, 2);
    test_seq("illegal_funct", 6'b000000, 6'b000111, 2);
    test_seq("ori", 6'b001101, 6'b000000, 2);
    test_seq("andi", 6'b001100, 6'b000000, 2);
    test_mid_reset();
    test_seq("after_reset_lw", 6'b100011, 6'b000000, 2);
    test_random(80);
    test_seq("final_fetch", 6'b000010, 6'b000000, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
